iiitb_rtc_param: RTL and testbench
==================================

// Module: iiitb_rtc_param
// PURPOSE
//   Parametrised 24h real-time clock: BCD HH:MM:SS from a single system clock.
//   Integrated prescaler with TICK_DIV; no derived clocks, all logic on clk.
//   Adds run/stop, validated time-load handshake, 12h display mode and day rollover pulse.
//   Optional alarm comparator with a sticky interrupt.
//   Sits between the board clock and the display/host logic.
// PARAMETERS
//   TICK_DIV  50_000_000        clk cycles per second; legal range >= 2
//   DIV_W     $clog2(TICK_DIV)  prescaler width; localparam, not overridable
// PORTS
//   clk        in   1   system clock; all state updates on posedge
//   rst        in   1   asynchronous, active-high reset
//   run        in   1   1 = prescaler counts; 0 = time frozen
//   mode_12h   in   1   0 = 24h display, 1 = 12h display
//   load_valid in   1   load request
//   load_bcd   in   24  {hrm,hrl,minm,minl,secm,secl}; always 24h format
//   load_ready out  1   load accepted when load_valid & load_ready
//   load_err   out  1   1-cycle pulse when a load request is rejected
//   hrm,hrl    out  4   displayed hour digits (BCD)
//   minm,minl  out  4   minute digits (BCD)
//   secm,secl  out  4   second digits (BCD)
//   pm         out  1   1 when internal hour >= 12, in either mode
//   sec_tick   out  1   1-cycle pulse on every second advance
//   day_tick   out  1   1-cycle pulse on 23:59:59 -> 00:00:00
// BEHAVIOUR
// - Reset: all time digits 0, prescaler 0; sec_tick, day_tick, load_err = 0; load_ready = 0.
// - Prescaler:
//   - Counts 0..TICK_DIV-1 while run=1; holds its value while run=0.
//   - On the edge where it wraps from TICK_DIV-1 to 0: time advances, and sec_tick is high the following cycle (registered).
// - Advance: BCD cascade secl(0-9), secm(0-5), minl(0-9), minm(0-5), hour (00-23).
// - 23:59:59 rolls over to 00:00:00; day_tick pulses together with that sec_tick.
// - load_ready: 1 in every cycle after reset deasserts; the handshake never stalls.
// - Load validity rule: every digit is <= 9, secm <= 5, minm <= 5, hrm <= 2, and hrm == 2 implies hrl <= 3.
// - Valid load:
//   - Time takes load_bcd on the next edge and the prescaler clears to 0.
//   - Load wins over a same-cycle tick; that tick is dropped and sec_tick stays 0.
//   - Works with run=0.
// - Invalid load: time and prescaler unchanged; load_err = 1 on the next cycle for one cycle; a same-cycle tick still advances time.
// - Display: combinational from the time registers and mode_12h; a mode change takes effect in the same cycle.
//   - mode_12h=0: hour digits equal the internal hour.
//   - mode_12h=1: internal 00 displays 12; 01-12 display unchanged; 13-23 display internal hour minus 12.
// - rst mid-operation clears everything immediately; no tick or load completes.
// CONFIGURATION
//   RTC_ALARM_EN defined:
//   - Extra ports:
//     - alarm_wr   in  1: write strobe for the alarm time.
//     - alarm_bcd  in  16: {hrm,hrl,minm,minl} in 24h format; alarm register written when alarm_wr=1 (value not validated).
//     - alarm_arm  in  1: 1 = alarm enabled.
//     - alarm_ack  in  1: clears the interrupt.
//     - alarm_irq  out 1: sticky alarm interrupt.
//   - Set condition: alarm_arm=1 and a tick advances time to exactly the alarm HH:MM:00.
//   - alarm_irq sets on the edge that produces that time and stays high until alarm_ack.
//   - Set and ack in the same cycle: set wins.
//   - A load to the alarm time does not fire.
//   - Reset clears the alarm register and alarm_irq.
//   RTC_ALARM_EN undefined: alarm ports and logic absent; all other behaviour identical.
// TESTING (TICK_DIV=4)
// 1. rst pulse, run=1 for 240 cycles -> 00:01:00; sec_tick high 1 of every 4 cycles; no day_tick.
// 2. Load 23:59:58, wait 8 cycles -> 23:59:59, then 00:00:00; day_tick coincident with the second sec_tick.
// 3. Load 24:00:00, then 12:60:00 -> load_err pulses once per request; time unchanged.
// 4. mode_12h=1 -> loads 00:15:00 shows 12:15 pm=0; 12:00:00 shows 12 pm=1; 13:05:00 shows 01 pm=1.
// 5. load_valid on a wrap edge with run=0 then run=1 -> loaded value held, no sec_tick that cycle; next sec_tick after 4 run cycles.
// 6. [RTC_ALARM_EN] Alarm 00:01, arm=1, load 00:00:58 -> irq rises at 00:01:00 and holds until ack.
//    - ack + re-fire in the same cycle -> irq stays 1.
//    - rst mid-run -> irq=0 and time=00:00:00.

Source files
------------

// File: rtl/iiitb_rtc_param.sv
// iiitb_rtc_param: 24h BCD real-time clock with built-in prescaler, validated load handshake,
// 12h display mode and day rollover pulse. Define RTC_ALARM_EN to add the HH:MM alarm with sticky irq.
module iiitb_rtc_param #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        mode_12h,
    input  logic        load_valid,
    input  logic [23:0] load_bcd,
    output logic        load_ready,
    output logic        load_err,
    output logic [3:0]  hrm,
    output logic [3:0]  hrl,
    output logic [3:0]  minm,
    output logic [3:0]  minl,
    output logic [3:0]  secm,
    output logic [3:0]  secl,
    output logic        pm,
    output logic        sec_tick,
`ifdef RTC_ALARM_EN
    input  logic        alarm_wr,
    input  logic [15:0] alarm_bcd,
    input  logic        alarm_arm,
    input  logic        alarm_ack,
    output logic        alarm_irq,
`endif
    output logic        day_tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    typedef struct packed {
        logic [3:0] hrm, hrl, minm, minl, secm, secl;
    } bcd_time_t;

    bcd_time_t        time_q, time_d, time_nxt, load_time;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             sec_tick_q, sec_tick_d;
    logic             day_tick_q, day_tick_d;
    logic             load_err_q, load_err_d;
    logic             load_ready_q, load_ready_d;
    logic             wrap, load_fire, load_ok, load_take, advance, rollover;

    assign load_time = bcd_time_t'(load_bcd);
    assign wrap      = run && (presc_q == DIV_MAX);
    assign load_fire = load_valid && load_ready_q;
    assign load_ok   = (load_time.secl <= 4'd9) && (load_time.secm <= 4'd5) &&
                       (load_time.minl <= 4'd9) && (load_time.minm <= 4'd5) &&
                       (load_time.hrl  <= 4'd9) && (load_time.hrm  <= 4'd2) &&
                       !((load_time.hrm == 4'd2) && (load_time.hrl > 4'd3));
    // A valid load swallows a coincident tick; a rejected one leaves it alone.
    assign load_take = load_fire && load_ok;
    assign advance   = wrap && !load_take;
    assign rollover  = (time_q == bcd_time_t'(24'h235959));

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        time_nxt = time_q;
        if (time_q.secl != 4'd9) begin
            time_nxt.secl = time_q.secl + 4'd1;
        end else begin
            time_nxt.secl = 4'd0;
            if (time_q.secm != 4'd5) begin
                time_nxt.secm = time_q.secm + 4'd1;
            end else begin
                time_nxt.secm = 4'd0;
                if (time_q.minl != 4'd9) begin
                    time_nxt.minl = time_q.minl + 4'd1;
                end else begin
                    time_nxt.minl = 4'd0;
                    if (time_q.minm != 4'd5) begin
                        time_nxt.minm = time_q.minm + 4'd1;
                    end else begin
                        time_nxt.minm = 4'd0;
                        if ((time_q.hrm == 4'd2) && (time_q.hrl == 4'd3)) begin
                            time_nxt.hrm = 4'd0;
                            time_nxt.hrl = 4'd0;
                        end else if (time_q.hrl == 4'd9) begin
                            time_nxt.hrm = time_q.hrm + 4'd1;
                            time_nxt.hrl = 4'd0;
                        end else begin
                            time_nxt.hrl = time_q.hrl + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        presc_d = presc_q;
        if (load_take) begin
            presc_d = '0;
        end else if (run) begin
            presc_d = wrap ? '0 : presc_q + DIV_W'(1);
        end
        time_d       = load_take ? load_time : (advance ? time_nxt : time_q);
        sec_tick_d   = advance;
        day_tick_d   = advance && rollover;
        load_err_d   = load_fire && !load_ok;
        load_ready_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q       <= '0;
            presc_q      <= '0;
            sec_tick_q   <= 1'b0;
            day_tick_q   <= 1'b0;
            load_err_q   <= 1'b0;
            load_ready_q <= 1'b0;
        end else begin
            time_q       <= time_d;
            presc_q      <= presc_d;
            sec_tick_q   <= sec_tick_d;
            day_tick_q   <= day_tick_d;
            load_err_q   <= load_err_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign load_ready = load_ready_q;
    assign load_err   = load_err_q;
    assign sec_tick   = sec_tick_q;
    assign day_tick   = day_tick_q;
    assign minm       = time_q.minm;
    assign minl       = time_q.minl;
    assign secm       = time_q.secm;
    assign secl       = time_q.secl;
    assign pm         = (time_q.hrm == 4'd2) || ((time_q.hrm == 4'd1) && (time_q.hrl >= 4'd2));

    // 12h remap in BCD: 00->12, 13..19 and 22..23 subtract 12 digit-wise, 20..21 -> 08..09.
    always_comb begin
        hrm = time_q.hrm;
        hrl = time_q.hrl;
        if (mode_12h) begin
            if ((time_q.hrm == 4'd0) && (time_q.hrl == 4'd0)) begin
                hrm = 4'd1;
                hrl = 4'd2;
            end else if ((time_q.hrm == 4'd1) && (time_q.hrl >= 4'd3)) begin
                hrm = 4'd0;
                hrl = time_q.hrl - 4'd2;
            end else if ((time_q.hrm == 4'd2) && (time_q.hrl <= 4'd1)) begin
                hrm = 4'd0;
                hrl = time_q.hrl + 4'd8;
            end else if (time_q.hrm == 4'd2) begin
                hrm = 4'd1;
                hrl = time_q.hrl - 4'd2;
            end
        end
    end

`ifdef RTC_ALARM_EN
    logic [15:0] alarm_q, alarm_d;
    logic        irq_q, irq_d;
    logic        alarm_hit;

    // Only a real tick can fire; a load to the alarm time never advances, so it never fires.
    assign alarm_hit = alarm_arm && advance &&
                       ({time_nxt.hrm, time_nxt.hrl, time_nxt.minm, time_nxt.minl} == alarm_q) &&
                       (time_nxt.secm == 4'd0) && (time_nxt.secl == 4'd0);

    always_comb begin
        alarm_d = alarm_wr ? alarm_bcd : alarm_q;
        irq_d   = irq_q;
        if (alarm_hit) begin
            irq_d = 1'b1;
        end else if (alarm_ack) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
            irq_q   <= irq_d;
        end
    end

    assign alarm_irq = irq_q;
`endif

endmodule

// File: tb/tb_iiitb_rtc_param.sv
// Scoreboard bench for iiitb_rtc_param at TICK_DIV=4; expected sec_tick/load_err events are queued
// by the stimulus and popped by an independent monitor. Define RTC_ALARM_EN to cover the alarm.
module tb_iiitb_rtc_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        mode_12h = 1'b0;
    logic        load_valid = 1'b0;
    logic [23:0] load_bcd = '0;
    logic        load_ready, load_err, pm, sec_tick, day_tick;
    logic [3:0]  hrm, hrl, minm, minl, secm, secl;
`ifdef RTC_ALARM_EN
    logic        alarm_wr = 1'b0;
    logic [15:0] alarm_bcd = '0;
    logic        alarm_arm = 1'b0;
    logic        alarm_ack = 1'b0;
    logic        alarm_irq;
`endif

    iiitb_rtc_param #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .run(run), .mode_12h(mode_12h),
        .load_valid(load_valid), .load_bcd(load_bcd), .load_ready(load_ready), .load_err(load_err),
        .hrm(hrm), .hrl(hrl), .minm(minm), .minl(minl), .secm(secm), .secl(secl),
        .pm(pm), .sec_tick(sec_tick),
`ifdef RTC_ALARM_EN
        .alarm_wr(alarm_wr), .alarm_bcd(alarm_bcd), .alarm_arm(alarm_arm),
        .alarm_ack(alarm_ack), .alarm_irq(alarm_irq),
`endif
        .day_tick(day_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] t;
        logic        day;
    } tick_exp_t;

    tick_exp_t   tick_q[$];
    int          err_pending = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          tick_cnt = 0;
    logic [23:0] dut_time;

    assign dut_time = {hrm, hrl, minm, minl, secm, secl};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else n_pass++;
    endtask

    function automatic logic [23:0] bcd_of(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    task automatic push_tick(input logic [23:0] t, input logic day);
        tick_exp_t e;
        e.t   = t;
        e.day = day;
        tick_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the load edge.
    task automatic do_load(input logic [23:0] bcd, input logic run_v);
        load_valid = 1'b1;
        load_bcd   = bcd;
        run        = run_v;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sec_tick) begin
                tick_cnt++;
                if (tick_q.size() == 0) begin
                    check("unexpected_sec_tick", {31'd0, sec_tick}, 32'd0);
                end else begin
                    tick_exp_t e;
                    e = tick_q.pop_front();
                    check("tick_time", {8'd0, dut_time}, {8'd0, e.t});
                    check("tick_day", {31'd0, day_tick}, {31'd0, e.day});
                end
            end else if (day_tick) begin
                check("day_tick_without_sec_tick", {31'd0, day_tick}, 32'd0);
            end
            if (load_err) begin
                if (err_pending == 0) check("unexpected_load_err", {31'd0, load_err}, 32'd0);
                else err_pending--;
            end
        end
    end

    initial begin
        int cnt0;
        // Reset state
        #1;
        check("rst_time", {8'd0, dut_time}, 32'd0);
        check("rst_outputs", {28'd0, sec_tick, day_tick, load_err, load_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("load_ready_after_rst", {31'd0, load_ready}, 32'd1);

        // 1: free run for one minute
        for (int s = 1; s <= 60; s++) push_tick(bcd_of(s), 1'b0);
        cnt0 = tick_cnt;
        run  = 1'b1;
        repeat (240) @(posedge clk);
        @(negedge clk);
        #1;
        run = 1'b0;
        check("minute_time", {8'd0, dut_time}, 32'h000100);
        check("minute_tick_count", tick_cnt - cnt0, 32'd60);
        @(posedge clk);
        #1;

        // 2: day rollover
        push_tick(24'h235959, 1'b0);
        push_tick(24'h000000, 1'b1);
        do_load(24'h235958, 1'b1);
        check("load_time", {8'd0, dut_time}, 32'h235958);
        repeat (8) @(posedge clk);
        #1;
        run = 1'b0;
        check("rollover_time", {8'd0, dut_time}, 32'h000000);

        // 3: rejected loads
        err_pending++;
        do_load(24'h240000, 1'b0);
        check("bad_hour_time", {8'd0, dut_time}, 32'h000000);
        err_pending++;
        do_load(24'h126000, 1'b0);
        check("bad_min_time", {8'd0, dut_time}, 32'h000000);

        // 4: 12h display
        mode_12h = 1'b1;
        do_load(24'h001500, 1'b0);
        check("h12_midnight", {23'd0, hrm, hrl, pm}, {23'd0, 8'h12, 1'b0});
        check("h12_minutes", {24'd0, minm, minl}, 32'h15);
        do_load(24'h120000, 1'b0);
        check("h12_noon", {23'd0, hrm, hrl, pm}, {23'd0, 8'h12, 1'b1});
        do_load(24'h130500, 1'b0);
        check("h12_13h", {23'd0, hrm, hrl, pm}, {23'd0, 8'h01, 1'b1});
        do_load(24'h201000, 1'b0);
        check("h12_20h", {23'd0, hrm, hrl, pm}, {23'd0, 8'h08, 1'b1});
        do_load(24'h230000, 1'b0);
        check("h12_23h", {23'd0, hrm, hrl, pm}, {23'd0, 8'h11, 1'b1});
        mode_12h = 1'b0;
        #1;
        check("h24_same_cycle", {23'd0, hrm, hrl, pm}, {23'd0, 8'h23, 1'b1});
        do_load(24'h110000, 1'b0);
        check("h24_11h", {23'd0, hrm, hrl, pm}, {23'd0, 8'h11, 1'b0});

        // 5: load while stopped, then load on a wrap edge
        do_load(24'h102030, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("held_while_stopped", {8'd0, dut_time}, 32'h102030);
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push_tick(24'h050608, 1'b0);
        do_load(24'h050607, 1'b1);
        check("load_beats_tick", {8'd0, dut_time}, 32'h050607);
        check("no_tick_on_load", {31'd0, sec_tick}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("no_tick_early", {8'd0, dut_time}, 32'h050607);
        @(posedge clk);
        #1;
        check("tick_after_4", {8'd0, dut_time}, 32'h050608);
        repeat (3) @(posedge clk);
        #1;
        err_pending++;
        push_tick(24'h050609, 1'b0);
        do_load(24'h350607, 1'b1);
        run = 1'b0;
        check("bad_load_keeps_tick", {8'd0, dut_time}, 32'h050609);
        @(posedge clk);
        #1;

`ifdef RTC_ALARM_EN
        // 6: alarm
        alarm_bcd = 16'h0001;
        alarm_wr  = 1'b1;
        alarm_arm = 1'b1;
        @(posedge clk);
        #1;
        alarm_wr = 1'b0;
        push_tick(24'h000059, 1'b0);
        push_tick(24'h000100, 1'b0);
        push_tick(24'h000101, 1'b0);
        push_tick(24'h000102, 1'b0);
        do_load(24'h000058, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("irq_before", {31'd0, alarm_irq}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("irq_fire", {31'd0, alarm_irq}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        check("irq_sticky", {31'd0, alarm_irq}, 32'd1);
        push_tick(24'h000100, 1'b0);
        do_load(24'h000059, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        alarm_ack = 1'b1;
        @(posedge clk);
        #1;
        alarm_ack = 1'b0;
        check("irq_set_beats_ack", {31'd0, alarm_irq}, 32'd1);
        alarm_ack = 1'b1;
        @(posedge clk);
        #1;
        alarm_ack = 1'b0;
        check("irq_ack", {31'd0, alarm_irq}, 32'd0);
        do_load(24'h000100, 1'b1);
        check("irq_no_fire_on_load", {31'd0, alarm_irq}, 32'd0);
`endif

        // Reset mid-run
        run = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_time", {8'd0, dut_time}, 32'd0);
        check("midrun_rst_flags", {29'd0, sec_tick, load_err, load_ready}, 32'd0);
`ifdef RTC_ALARM_EN
        check("midrun_rst_irq", {31'd0, alarm_irq}, 32'd0);
`endif
        run = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

`ifdef RTC_ALARM_EN
        // Alarm register came back as 00:00 after reset, so midnight fires.
        push_tick(24'h000000, 1'b1);
        do_load(24'h235959, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        run = 1'b0;
        check("irq_after_rst_alarm_cleared", {31'd0, alarm_irq}, 32'd1);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("tick_queue_drained", tick_q.size(), 32'd0);
        check("err_queue_drained", err_pending, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
